dac_scheduler: RTL
==================

DAC_SCHEDULER -- requirements
Module: dac_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 4096, cycles allowed per wait state before abort.
REQ-002 Parameter: NUM_CH, 4, number of requesters; fixed at 4, with channel index width of 2.
REQ-003 clk  input  1  single clock; all logic is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ch_req  input  4  per-channel update request, sampled each cycle; bit i = channel i.
REQ-006 ch_value  input  48  packed 12-bit codes; channel i occupies bits [12i+11:12i].
REQ-007 dac_busy  input  1  busy flag from the downstream DAC writer (high while the I2C transfer is active).
REQ-008 dac_start  output  1  one-cycle write strobe to the DAC writer.
REQ-009 dac_reg  output  5  MCP47FEB volatile DAC register address; equals the granted channel index.
REQ-010 dac_value  output  16  write data; equals {4'b0000, latched 12-bit code}.
REQ-011 pending  output  4  per-channel pending-update flags.
REQ-012 done  output  1  one-cycle pulse when a write completes.
REQ-013 done_ch  output  2  index of the completed or aborted channel; valid when done or timeout_err is high.
REQ-014 timeout_err  output  1  one-cycle pulse when a write is aborted by timeout.
REQ-015 sched_busy  output  1  high whenever the state is not IDLE.

Function
REQ-016 Each channel SHALL have a 12-bit shadow register and a pending bit; ch_req[i]=1 loads shadow[i] from ch_value and sets pending[i].
REQ-017 Coalescing: a request to an already-pending channel SHALL overwrite its shadow value; only the newest value is written.
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE with pending != 0: grant the first pending channel in round-robin order starting at last_grant+1 (mod 4).
REQ-020 On grant, in the same edge: load dac_value from the shadow, load dac_reg with the index, clear pending for that channel, set done_ch to the index, go to ISSUE.
REQ-021 A ch_req on the granted channel in the grant cycle SHALL win: pending stays set, the shadow takes the new value, and dac_value takes the old shadow value.
REQ-022 ISSUE: dac_start=1 for exactly one cycle, clear the timeout counter, then go to WAIT_BUSY.
REQ-023 WAIT_BUSY: dac_busy=1 -> go to WAIT_DONE and clear the counter.
REQ-024 WAIT_DONE: dac_busy=0 -> pulse done, set last_grant to the granted index, go to IDLE.
REQ-025 Timeout: in either wait state, when the counter reaches TIMEOUT_CYCLES-1 -> pulse timeout_err, set pending for the aborted channel again, update last_grant, go to IDLE.
REQ-026 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES)) bits wide, increment by 1 per wait cycle, and never wrap.
REQ-027 dac_reg and dac_value SHALL stay stable from grant until the next grant.
REQ-028 Minimum turnaround SHALL be one IDLE cycle between done and the next dac_start.
REQ-029 Requests arriving in any state SHALL be latched and never lost.
REQ-030 No write SHALL be issued while pending == 0.

Reset
REQ-031 rst=1 asynchronously SHALL force: state IDLE; pending=0; shadows=0; last_grant=3 (so channel 0 wins first); counter=0.
REQ-032 rst=1 asynchronously SHALL force all outputs to 0, including dac_start, done, timeout_err, sched_busy, dac_reg, dac_value and done_ch.
REQ-033 Reset mid-transfer SHALL abort silently with no done or timeout_err pulse; all pending requests are discarded.

Verification
REQ-034 Single request: ch_req=4'b0010 with ch1=12'hABC, writer model busy for 10 cycles -> dac_start after 2 cycles, dac_reg=1, dac_value=16'h0ABC, then done with done_ch=1.
REQ-035 Fairness: ch_req=4'b1111 in one cycle -> write order 0,1,2,3; then re-request 0 and 2 -> order 0,2.
REQ-036 Coalescing: request ch3=12'h111, then ch3=12'h222 while ch0 is in WAIT_DONE -> exactly one ch3 write, with value 16'h0222.
REQ-037 Timeout: dac_busy held at 0 -> timeout_err after TIMEOUT_CYCLES wait cycles, pending bit re-set, channel retried after others in round-robin order.
REQ-038 Collision: ch_req on the granted channel in the grant cycle -> old value written first, then a second write of the new value.
REQ-039 Reset during WAIT_DONE -> all outputs 0 immediately, no done pulse, pending=0.

Source files
------------

// File: rtl/dac_scheduler_if.sv
// rtl/dac_scheduler_if.sv - request/DAC-writer handshake bundle for dac_scheduler
//
// Signals:
//   ch_req      4   per-channel update request (bit i = channel i)
//   ch_value    48  packed 12-bit codes, channel i in [12i+11:12i]
//   dac_busy    1   downstream DAC writer busy flag
//   dac_start   1   one-cycle write strobe to the writer
//   dac_reg     5   DAC register address (granted channel index)
//   dac_value   16  write data {4'b0, code}
//   pending     4   per-channel pending-update flags
//   done        1   write-complete pulse
//   done_ch     2   channel of the completed/aborted write
//   timeout_err 1   write-aborted pulse
//   sched_busy  1   scheduler not idle
// Modports: slave = scheduler side, master = requesters + writer side.
interface dac_scheduler_if;
  logic [3:0]  ch_req;
  logic [47:0] ch_value;
  logic        dac_busy;
  logic        dac_start;
  logic [4:0]  dac_reg;
  logic [15:0] dac_value;
  logic [3:0]  pending;
  logic        done;
  logic [1:0]  done_ch;
  logic        timeout_err;
  logic        sched_busy;

  modport slave (
    input  ch_req, ch_value, dac_busy,
    output dac_start, dac_reg, dac_value, pending, done, done_ch,
           timeout_err, sched_busy
  );

  modport master (
    output ch_req, ch_value, dac_busy,
    input  dac_start, dac_reg, dac_value, pending, done, done_ch,
           timeout_err, sched_busy
  );
endinterface

// File: rtl/dac_scheduler.sv
// rtl/dac_scheduler.sv - round-robin coalescing scheduler for a 4-channel I2C DAC writer
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - dac_scheduler_if.slave (requests in, DAC writer handshake and status out)
// Parameters:
//   TIMEOUT_CYCLES - cycles allowed in each wait state before the write is aborted
//   NUM_CH         - number of requesters (fixed at 4)
module dac_scheduler #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int NUM_CH         = 4
) (
  input  logic           clk,
  input  logic           rst,
  dac_scheduler_if.slave bus
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state;
  logic [11:0]   shadow [NUM_CH];
  logic [3:0]    pending_q;
  logic [1:0]    last_grant;
  logic [1:0]    grant;
  logic [CW-1:0] cnt;

  logic [1:0]    rr_idx;
  logic [1:0]    cand;
  logic          rr_found;
  logic [3:0]    rr_onehot;
  logic [3:0]    grant_onehot;

  assign bus.pending   = pending_q;
  assign rr_onehot     = 4'b0001 << rr_idx;
  assign grant_onehot  = 4'b0001 << grant;

  // First pending channel scanning last_grant+1, +2, ... with 2-bit wrap.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = last_grant + 2'(k);
      if (!rr_found && pending_q[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      pending_q       <= '0;
      last_grant      <= 2'd3;
      grant           <= '0;
      cnt             <= '0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
      bus.dac_start   <= 1'b0;
      bus.dac_reg     <= '0;
      bus.dac_value   <= '0;
      bus.done        <= 1'b0;
      bus.done_ch     <= '0;
      bus.timeout_err <= 1'b0;
      bus.sched_busy  <= 1'b0;
    end else begin
      bus.dac_start   <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;

      // New requests always land; later pending_q writes below fold them in.
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.ch_req[i]) shadow[i] <= bus.ch_value[12*i +: 12];
      end
      pending_q <= pending_q | bus.ch_req;

      case (state)
        IDLE: begin
          if (rr_found) begin
            grant          <= rr_idx;
            bus.dac_reg    <= {3'b000, rr_idx};
            // Reads the pre-edge shadow, so a colliding request is written next time.
            bus.dac_value  <= {4'h0, shadow[rr_idx]};
            bus.done_ch    <= rr_idx;
            pending_q      <= (pending_q & ~rr_onehot) | bus.ch_req;
            bus.dac_start  <= 1'b1;
            bus.sched_busy <= 1'b1;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (bus.dac_busy) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            pending_q       <= pending_q | bus.ch_req | grant_onehot;
            last_grant      <= grant;
            bus.sched_busy  <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_DONE: begin
          if (!bus.dac_busy) begin
            bus.done       <= 1'b1;
            last_grant     <= grant;
            bus.sched_busy <= 1'b0;
            cnt            <= '0;
            state          <= IDLE;
          end else if (cnt == CNT_LAST) begin
            bus.timeout_err <= 1'b1;
            pending_q       <= pending_q | bus.ch_req | grant_onehot;
            last_grant      <= grant;
            bus.sched_busy  <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
